// File: rtl/alu_regfile_pc.sv
// Hephaestus datapath: 16-function combinational ALU + SREG, 8x8 register file (1-cycle reads), 8-bit PC.
// No backpressure; enables come from the sequencer. Define ALU_MUL_EN to build the 8x8 multiplier for fsl 2.
module alu_regfile_pc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic [2:0] ra_num,
  input  logic [2:0] rb_num,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  input  logic       wr_en,
  input  logic       wr_hi_en,
  input  logic [2:0] rc_num,
  input  logic [7:0] rc_data,
  input  logic [7:0] rc_hi_data,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [3:0] alu_fsl,
  output logic [7:0] alu_lo,
  output logic [7:0] alu_hi,
  output logic [3:0] alu_flags,
  input  logic       sreg_en,
  output logic [3:0] sreg,
  input  logic       jump,
  input  logic       hold,
  input  logic [7:0] jump_line,
  output logic [7:0] pc,
  output logic [7:0] pc_next
);

  localparam logic [3:0] FnAdd = 4'd0,  FnSub = 4'd1,  FnMul = 4'd2,  FnAnd = 4'd3;
  localparam logic [3:0] FnOr  = 4'd4,  FnXor = 4'd5,  FnNot = 4'd6,  FnNeg = 4'd7;
  localparam logic [3:0] FnShl = 4'd8,  FnShr = 4'd9,  FnAsr = 4'd10, FnRol = 4'd11;
  localparam logic [3:0] FnRor = 4'd12, FnInc = 4'd13, FnDec = 4'd14, FnCmp = 4'd15;

  logic [7:0] regs [8];
  logic [2:0] rcHiNum;
  assign rcHiNum = rc_num + 3'd1;

  // Reads sample the array before this edge's writes land, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      if (rd_en) begin
        ra_data <= regs[ra_num];
        rb_data <= regs[rb_num];
      end
      if (wr_en)    regs[rc_num]  <= rc_data;
      if (wr_hi_en) regs[rcHiNum] <= rc_hi_data;
    end
  end

  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic [7:0]  nzSrc;
  logic        cFlag;
  logic        vFlag;
  logic        zFlag;
  logic        nFlag;

  assign sum9  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff9 = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    lo    = '0;
    hi    = '0;
    cFlag = 1'b0;
    vFlag = 1'b0;
    case (alu_fsl)
      FnAdd: begin
        lo    = sum9[7:0];
        cFlag = sum9[8];
        vFlag = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      FnSub, FnCmp: begin
        lo    = (alu_fsl == FnCmp) ? alu_a : diff9[7:0];
        cFlag = diff9[8];
        vFlag = (alu_a[7] != alu_b[7]) && (diff9[7] != alu_a[7]);
      end
      FnMul: begin
`ifdef ALU_MUL_EN
        {hi, lo} = {8'd0, alu_a} * {8'd0, alu_b};
        cFlag    = |hi;
`endif
      end
      FnAnd: lo = alu_a & alu_b;
      FnOr:  lo = alu_a | alu_b;
      FnXor: lo = alu_a ^ alu_b;
      FnNot: lo = ~alu_a;
      FnNeg: begin
        lo    = 8'd0 - alu_a;
        cFlag = |alu_a;
        vFlag = (alu_a == 8'h80);
      end
      FnShl: begin lo = {alu_a[6:0], 1'b0};     cFlag = alu_a[7]; end
      FnShr: begin lo = {1'b0, alu_a[7:1]};     cFlag = alu_a[0]; end
      FnAsr: begin lo = {alu_a[7], alu_a[7:1]}; cFlag = alu_a[0]; end
      FnRol: begin lo = {alu_a[6:0], alu_a[7]}; cFlag = alu_a[7]; end
      FnRor: begin lo = {alu_a[0], alu_a[7:1]}; cFlag = alu_a[0]; end
      FnInc: begin
        {cFlag, lo} = {1'b0, alu_a} + 9'd1;
        vFlag       = (alu_a == 8'h7F);
      end
      FnDec: begin
        lo    = alu_a - 8'd1;
        cFlag = (alu_a == 8'h00);
        vFlag = (alu_a == 8'h80);
      end
    endcase
  end

  // CMP passes A through but reports N/Z of the subtraction; MUL judges N/Z on the full product.
  assign nzSrc = (alu_fsl == FnCmp) ? diff9[7:0] : lo;
  assign zFlag = (alu_fsl == FnMul) ? ({hi, lo} == 16'd0) : (nzSrc == 8'd0);
  assign nFlag = (alu_fsl == FnMul) ? hi[7] : nzSrc[7];

  assign alu_lo    = lo;
  assign alu_hi    = hi;
  assign alu_flags = {vFlag, nFlag, zFlag, cFlag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sreg <= '0;
    else if (sreg_en) sreg <= alu_flags;
  end

  assign pc_next = pc + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= '0;
    else if (jump)  pc <= jump_line;
    else if (!hold) pc <= pc_next;
  end

endmodule

// File: tb/tb_alu_regfile_pc.sv
// Scoreboarded bench: stimulus pushes model expectations per cycle, monitor pops and compares after each edge.
module tb_alu_regfile_pc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en, wr_en, wr_hi_en, sreg_en, jump, hold;
  logic [2:0] ra_num, rb_num, rc_num;
  logic [7:0] ra_data, rb_data, rc_data, rc_hi_data;
  logic [7:0] alu_a, alu_b, alu_lo, alu_hi, jump_line, pc, pc_next;
  logic [3:0] alu_fsl, alu_flags, sreg;

  alu_regfile_pc dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .ra_num(ra_num), .rb_num(rb_num),
    .ra_data(ra_data), .rb_data(rb_data), .wr_en(wr_en), .wr_hi_en(wr_hi_en),
    .rc_num(rc_num), .rc_data(rc_data), .rc_hi_data(rc_hi_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fsl(alu_fsl), .alu_lo(alu_lo), .alu_hi(alu_hi),
    .alu_flags(alu_flags), .sreg_en(sreg_en), .sreg(sreg), .jump(jump), .hold(hold),
    .jump_line(jump_line), .pc(pc), .pc_next(pc_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo, hi, fl, ra, rb, sr, pc, pcn;
  } exp_t;
  exp_t q[$];

  int nCmp = 0;
  int nBad = 0;

  // Reference state
  int mRegs [8];
  int mRa, mRb, mSreg, mPc;

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic void model_alu(input int f, input int a, input int b,
                                    output int lo, output int hi, output int fl);
    int r, nz, c, v, z, n;
    r = 0; c = 0; v = 0; hi = 0; lo = 0;
    case (f)
      0:  begin r = a + b; lo = r % 256; c = (r > 255); v = (sgn(a) + sgn(b) > 127 || sgn(a) + sgn(b) < -128); end
      1, 15: begin
        r = a - b; lo = (r + 256) % 256; c = (r < 0);
        v = (sgn(a) - sgn(b) > 127 || sgn(a) - sgn(b) < -128);
      end
      2:  begin
`ifdef ALU_MUL_EN
        r = a * b; lo = r % 256; hi = r / 256; c = (hi != 0);
`endif
      end
      3:  lo = a & b;
      4:  lo = a | b;
      5:  lo = a ^ b;
      6:  lo = 255 - a;
      7:  begin lo = (256 - a) % 256; c = (a != 0); v = (-sgn(a) > 127); end
      8:  begin lo = (a * 2) % 256; c = (a >= 128); end
      9:  begin lo = a / 2; c = a % 2; end
      10: begin lo = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      11: begin lo = (a * 2) % 256 + a / 128; c = (a >= 128); end
      12: begin lo = a / 2 + (a % 2) * 128; c = a % 2; end
      13: begin lo = (a + 1) % 256; c = (a == 255); v = (sgn(a) + 1 > 127); end
      14: begin lo = (a + 255) % 256; c = (a == 0); v = (sgn(a) - 1 < -128); end
      default: ;
    endcase
    nz = lo;
    if (f == 15) lo = a;
    if (f == 2) begin
      z = (hi == 0 && lo == 0);
      n = (hi >= 128);
    end else begin
      z = (nz == 0);
      n = (nz >= 128);
    end
    fl = v * 8 + n * 4 + z * 2 + c;
  endfunction

  // Issue the currently driven inputs for one clock, predicting post-edge outputs.
  task automatic cycle(input bit ovr = 0, input int oLo = 0, input int oHi = 0, input int oFl = 0);
    exp_t e;
    model_alu(alu_fsl, alu_a, alu_b, e.lo, e.hi, e.fl);
    if (ovr) begin e.lo = oLo; e.hi = oHi; e.fl = oFl; end
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mRegs[i] = 0;
      mRa = 0; mRb = 0; mSreg = 0; mPc = 0;
    end else begin
      if (rd_en) begin mRa = mRegs[ra_num]; mRb = mRegs[rb_num]; end
      if (wr_en)    mRegs[rc_num] = rc_data;
      if (wr_hi_en) mRegs[(rc_num + 1) % 8] = rc_hi_data;
      if (sreg_en)  mSreg = e.fl;
      if (jump)       mPc = jump_line;
      else if (!hold) mPc = (mPc + 1) % 256;
    end
    e.ra = mRa; e.rb = mRb; e.sr = mSreg; e.pc = mPc; e.pcn = (mPc + 1) % 256;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; wr_hi_en = 0; sreg_en = 0; jump = 0; hold = 0;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input int expv);
    nCmp++;
    if (act !== 16'(expv)) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_lo", 16'(alu_lo), e.lo);
        chk("alu_hi", 16'(alu_hi), e.hi);
        chk("alu_flags", 16'(alu_flags), e.fl);
        chk("ra_data", 16'(ra_data), e.ra);
        chk("rb_data", 16'(rb_data), e.rb);
        chk("sreg", 16'(sreg), e.sr);
        chk("pc", 16'(pc), e.pc);
        chk("pc_next", 16'(pc_next), e.pcn);
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 8; i++) mRegs[i] = 0;
    mRa = 0; mRb = 0; mSreg = 0; mPc = 0;
    rst_n = 0; idle();
    ra_num = 0; rb_num = 0; rc_num = 0; rc_data = 0; rc_hi_data = 0;
    alu_a = 0; alu_b = 0; alu_fsl = 0; jump_line = 0;
    @(negedge clk);
    rst_n = 1;

    // Register write/readback with read-before-write and hi-index wrap
    wr_en = 1; rc_num = 2; rc_data = 8'h5A; rd_en = 1; ra_num = 2; rb_num = 0; cycle();
    idle(); wr_hi_en = 1; rc_num = 7; rc_hi_data = 8'hC3; cycle();
    idle(); rd_en = 1; ra_num = 2; rb_num = 0; cycle();
    rd_en = 0; cycle();

    // Directed ALU vectors with literal expectations; sreg latched only on some
    idle();
    alu_fsl = 0;  alu_a = 8'h7F; alu_b = 8'h01; sreg_en = 1; cycle(1, 8'h80, 0, 4'b1100);
    alu_fsl = 1;  alu_a = 8'h00; alu_b = 8'h01; sreg_en = 0; cycle(1, 8'hFF, 0, 4'b0101);
    alu_fsl = 15; alu_a = 8'h05; alu_b = 8'h05; sreg_en = 1; cycle(1, 8'h05, 0, 4'b0010);
`ifdef ALU_MUL_EN
    alu_fsl = 2;  alu_a = 8'hFF; alu_b = 8'hFF; sreg_en = 0; cycle(1, 8'h01, 8'hFE, 4'b0101);
`else
    alu_fsl = 2;  alu_a = 8'hFF; alu_b = 8'hFF; sreg_en = 0; cycle(1, 8'h00, 8'h00, 4'b0010);
`endif
    alu_fsl = 8;  alu_a = 8'h81; cycle(1, 8'h02, 0, 4'b0001);
    alu_fsl = 10; alu_a = 8'h80; cycle(1, 8'hC0, 0, 4'b0100);
    alu_fsl = 12; alu_a = 8'h01; sreg_en = 1; cycle(1, 8'h80, 0, 4'b0101);
    alu_fsl = 5;  alu_a = 8'hF0; alu_b = 8'hFF; sreg_en = 0; cycle(1, 8'h0F, 0, 4'b0000);

    // PC: jump to 0xFE, wrap, hold, jump beats hold
    idle(); jump = 1; jump_line = 8'hFE; cycle();
    jump = 0; cycle(); cycle();
    hold = 1; cycle(); cycle();
    jump = 1; jump_line = 8'h40; cycle();
    idle(); cycle();

    // Mid-run reset with a write pending, then read r3/r7
    wr_en = 1; rc_num = 3; rc_data = 8'hAA; rst_n = 0; cycle();
    idle(); rst_n = 1; rd_en = 1; ra_num = 3; rb_num = 7; cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      rd_en      = $urandom_range(0, 1);
      wr_en      = $urandom_range(0, 1);
      wr_hi_en   = $urandom_range(0, 2) == 0;
      sreg_en    = $urandom_range(0, 1);
      jump       = $urandom_range(0, 7) == 0;
      hold       = $urandom_range(0, 3) == 0;
      ra_num     = 3'($urandom);
      rb_num     = 3'($urandom);
      rc_num     = 3'($urandom);
      rc_data    = 8'($urandom);
      rc_hi_data = 8'($urandom);
      alu_a      = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      alu_b      = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      alu_fsl    = 4'($urandom);
      jump_line  = 8'($urandom);
      cycle();
    end
    rst_n = 1; idle();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #3;
    nCmp++;
    if (q.size() != 0) begin
      nBad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
